// File: rtl/cube_pkg.sv
// Shared defaults, scan state encoding and width helpers for the LED cube scanner.
package cube_pkg;

    localparam int DEF_LAYERS    = 4;
    localparam int DEF_BPL       = 2;
    localparam int DEF_BASE_ADDR = 20;
    localparam int DEF_DWELL     = 8;
    localparam int DEF_BLANK     = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_BLANK = 2'd2,
        ST_SHOW  = 2'd3
    } scan_state_e;

    function automatic int col_w(input int bpl);
        return 8 * bpl;
    endfunction

    // Width of a counter that must hold values 0..max_val (never narrower than 1 bit).
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/cube_fetch_seq.sv
// Reads one layer's bytes from frame memory over req/gnt into a shadow register.
module cube_fetch_seq
    import cube_pkg::*;
#(
    parameter int BPL       = DEF_BPL,
    parameter int BASE_ADDR = DEF_BASE_ADDR,
    parameter int LYR_W     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LYR_W-1:0]     layer,
    input  logic                 gnt,
    input  logic [7:0]           dout,
    output logic                 req,
    output logic [7:0]           addr,
    output logic [8*BPL-1:0]     shadow_nxt,
    output logic                 done
);

    localparam int IDX_W = cnt_w(BPL - 1);

    logic [IDX_W-1:0]   idx;
    logic [8*BPL-1:0]   shadow;
    logic               capture;
    logic               last;

    assign capture = req && gnt;
    assign last    = (idx == IDX_W'(BPL - 1));
    // done is combinational so the top can load the complete layer on the final grant edge.
    assign done    = capture && last;

    always_comb begin
        shadow_nxt = shadow;
        if (capture) begin
            shadow_nxt[8*int'(idx) +: 8] = dout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req    <= 1'b0;
            addr   <= 8'd0;
            idx    <= '0;
            shadow <= '0;
        end else if (start) begin
            req  <= 1'b1;
            idx  <= '0;
            addr <= 8'(BASE_ADDR + BPL * int'(layer));
        end else if (capture) begin
            shadow <= shadow_nxt;
            if (last) begin
                req <= 1'b0;
                idx <= '0;
            end else begin
                idx  <= idx + 1'b1;
                addr <= addr + 8'd1;
            end
        end
    end

endmodule

// File: rtl/cube_layer_scan.sv
// Layer-multiplexed LED cube scanner: fetch a layer, blank, then light it for a fixed dwell.
module cube_layer_scan
    import cube_pkg::*;
#(
    parameter int LAYERS    = DEF_LAYERS,
    parameter int BPL       = DEF_BPL,
    parameter int BASE_ADDR = DEF_BASE_ADDR,
    parameter int DWELL     = DEF_DWELL,
    parameter int BLANK     = DEF_BLANK,
    localparam int COL_W    = col_w(BPL)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic [7:0]        mem_addr,
    input  logic [7:0]        mem_dout,
    output logic [LAYERS-1:0] layer_sel,
    output logic [COL_W-1:0]  col_data,
    output logic              frame_done,
    output logic              busy
);

    localparam int LYR_W = cnt_w(LAYERS - 1);
    localparam int CNT_W = cnt_w((DWELL > BLANK) ? DWELL : BLANK);

    if (BASE_ADDR + LAYERS * BPL > 256 || DWELL < 1 || BLANK < 1) begin : g_bad_params
        $error("cube_layer_scan: frame window exceeds memory or DWELL/BLANK below 1");
    end

    scan_state_e        state, state_nxt;
    logic [LYR_W-1:0]   layer, layer_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [LAYERS-1:0]  sel_nxt;
    logic [COL_W-1:0]   col_nxt;
    logic [COL_W-1:0]   shadow_nxt;
    logic               done_nxt;
    logic               start;
    logic               fetch_done;

    cube_fetch_seq #(
        .BPL       (BPL),
        .BASE_ADDR (BASE_ADDR),
        .LYR_W     (LYR_W)
    ) u_fetch (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .layer      (layer_nxt),
        .gnt        (mem_gnt),
        .dout       (mem_dout),
        .req        (mem_req),
        .addr       (mem_addr),
        .shadow_nxt (shadow_nxt),
        .done       (fetch_done)
    );

    always_comb begin
        state_nxt = state;
        layer_nxt = layer;
        cnt_nxt   = cnt;
        sel_nxt   = layer_sel;
        col_nxt   = col_data;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                sel_nxt = '0;
                col_nxt = '0;
                if (en) begin
                    state_nxt = ST_FETCH;
                    layer_nxt = '0;
                end
            end
            ST_FETCH: begin
                // Previous layer stays lit until the new one is fully captured.
                if (fetch_done) begin
                    state_nxt = ST_BLANK;
                    cnt_nxt   = '0;
                    sel_nxt   = '0;
                    col_nxt   = shadow_nxt;
                end
            end
            ST_BLANK: begin
                if (cnt == CNT_W'(BLANK - 1)) begin
                    state_nxt = ST_SHOW;
                    cnt_nxt   = '0;
                    sel_nxt   = LAYERS'(1) << layer;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_SHOW: begin
                if (cnt == CNT_W'(DWELL - 1)) begin
                    cnt_nxt = '0;
                    if (layer == LYR_W'(LAYERS - 1)) begin
                        layer_nxt = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        layer_nxt = layer + 1'b1;
                    end
                    if (en) begin
                        state_nxt = ST_FETCH;
                    end else begin
                        state_nxt = ST_IDLE;
                        sel_nxt   = '0;
                        col_nxt   = '0;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign start = (state_nxt == ST_FETCH) && (state != ST_FETCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            layer      <= '0;
            cnt        <= '0;
            layer_sel  <= '0;
            col_data   <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            layer      <= layer_nxt;
            cnt        <= cnt_nxt;
            layer_sel  <= sel_nxt;
            col_data   <= col_nxt;
            frame_done <= done_nxt;
            busy       <= (state_nxt != ST_IDLE);
        end
    end

endmodule
